// File: rtl/ym_bus_writer.sv
// Host-side writer for the YM/PSG CPU port: queues (addr,data) writes and replays each
// as an address strobe then a data strobe, timed in chip clocks. Option: YM_WRITER_ADDR_CACHE_EN.
module ym_bus_writer #(
  parameter int STB_LEN   = 2,
  parameter int ADDR_WAIT = 12,
  parameter int DATA_WAIT = 84,
  parameter int FIFO_LOG2 = 2,
  parameter int CNT_W     = 8
) (
  input  logic       MCLK,
  input  logic       reset,
  input  logic       ce,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_data,
  output logic       chip_cs_n,
  output logic       chip_wr_n,
  output logic       chip_a0,
  output logic [7:0] chip_d,
  output logic       busy
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam logic [CNT_W-1:0]     STB_M1   = CNT_W'(STB_LEN - 1);
  localparam logic [CNT_W-1:0]     AWAIT_M1 = CNT_W'(ADDR_WAIT - 1);
  localparam logic [CNT_W-1:0]     DWAIT_M1 = CNT_W'(DATA_WAIT - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [FIFO_LOG2-1:0] PTR_ONE  = FIFO_LOG2'(1);
  localparam logic [FIFO_LOG2:0]   QCNT_ONE = (FIFO_LOG2 + 1)'(1);
  localparam logic [FIFO_LOG2:0]   QCNT_MAX = (FIFO_LOG2 + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    A_STB  = 3'd1,
    A_WAIT = 3'd2,
    D_STB  = 3'd3,
    D_WAIT = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Write queue. Handshake: a request is accepted on an MCLK edge where
  // req_valid && req_ready; req_ready is registered and only reflects !full.
  // ---------------------------------------------------------------------------
  logic [7:0]           q_addr [DEPTH];
  logic [7:0]           q_data [DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr;
  logic [FIFO_LOG2-1:0] rd_ptr;
  logic [FIFO_LOG2:0]   q_count;
  logic [FIFO_LOG2:0]   q_count_nx;
  logic                 push;
  logic                 pop;
  logic                 q_empty;
  logic [7:0]           head_addr;
  logic [7:0]           head_data;

  assign push      = req_valid && req_ready;
  assign q_empty   = (q_count == '0);
  assign head_addr = q_addr[rd_ptr];
  assign head_data = q_data[rd_ptr];

  always_comb begin
    q_count_nx = q_count;
    case ({push, pop})
      2'b10:   q_count_nx = q_count + QCNT_ONE;
      2'b01:   q_count_nx = q_count - QCNT_ONE;
      default: q_count_nx = q_count;
    endcase
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      q_count   <= '0;
      req_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      q_count   <= q_count_nx;
      req_ready <= (q_count_nx != QCNT_MAX);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge MCLK) begin
    if (push) begin
      q_addr[wr_ptr] <= req_addr;
      q_data[wr_ptr] <= req_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Transfer FSM
  // ---------------------------------------------------------------------------
  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic [7:0]       cur_addr;
  logic [7:0]       cur_data;
  logic             skip_addr;
  logic             a_stb_done;
  logic             cs_nx;
  logic             wr_nx;
  logic             a0_nx;
  logic [7:0]       d_nx;
  logic [7:0]       ent_addr;
  logic [7:0]       ent_data;

  assign a_stb_done = ce && (state == A_STB) && (cnt == '0);

`ifdef YM_WRITER_ADDR_CACHE_EN
  logic [7:0] last_addr;
  logic       last_valid;

  // A repeat of the address already latched in the chip needs only the data phase.
  assign skip_addr = last_valid && (head_addr == last_addr);

  always_ff @(posedge MCLK) begin
    if (reset) begin
      last_addr  <= '0;
      last_valid <= 1'b0;
    end else if (a_stb_done) begin
      last_addr  <= cur_addr;
      last_valid <= 1'b1;
    end
  end
`else
  assign skip_addr = 1'b0;
`endif

  // State register, counter, entry latch and registered bus outputs.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cur_addr  <= '0;
      cur_data  <= '0;
      chip_cs_n <= 1'b1;
      chip_wr_n <= 1'b1;
      chip_a0   <= 1'b0;
      chip_d    <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      chip_cs_n <= cs_nx;
      chip_wr_n <= wr_nx;
      chip_a0   <= a0_nx;
      chip_d    <= d_nx;
      if (pop) begin
        cur_addr <= head_addr;
        cur_data <= head_data;
      end
    end
  end

  // Next-state logic: nothing moves without ce.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pop      = 1'b0;
    if (ce) begin
      case (state)
        IDLE: begin
          if (!q_empty) begin
            pop      = 1'b1;
            state_nx = skip_addr ? D_STB : A_STB;
            cnt_nx   = STB_M1;
          end
        end
        A_STB: begin
          if (cnt == '0) begin
            state_nx = A_WAIT;
            cnt_nx   = AWAIT_M1;
          end else begin
            cnt_nx = cnt - CNT_ONE;
          end
        end
        A_WAIT: begin
          if (cnt == '0) begin
            state_nx = D_STB;
            cnt_nx   = STB_M1;
          end else begin
            cnt_nx = cnt - CNT_ONE;
          end
        end
        D_STB: begin
          if (cnt == '0) begin
            state_nx = D_WAIT;
            cnt_nx   = DWAIT_M1;
          end else begin
            cnt_nx = cnt - CNT_ONE;
          end
        end
        D_WAIT: begin
          if (cnt != '0) begin
            cnt_nx = cnt - CNT_ONE;
          end else if (!q_empty) begin
            pop      = 1'b1;
            state_nx = skip_addr ? D_STB : A_STB;
            cnt_nx   = STB_M1;
          end else begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // Output logic: bus values for the state being entered, registered above.
  always_comb begin
    ent_addr = pop ? head_addr : cur_addr;
    ent_data = pop ? head_data : cur_data;
    cs_nx    = 1'b1;
    wr_nx    = 1'b1;
    a0_nx    = chip_a0;
    d_nx     = chip_d;
    case (state_nx)
      A_STB: begin
        cs_nx = 1'b0;
        wr_nx = 1'b0;
        a0_nx = 1'b0;
        d_nx  = ent_addr;
      end
      A_WAIT: begin
        a0_nx = 1'b0;
        d_nx  = ent_addr;
      end
      D_STB: begin
        cs_nx = 1'b0;
        wr_nx = 1'b0;
        a0_nx = 1'b1;
        d_nx  = ent_data;
      end
      D_WAIT: begin
        a0_nx = 1'b1;
        d_nx  = ent_data;
      end
      default: begin
        cs_nx = 1'b1;
        wr_nx = 1'b1;
      end
    endcase
  end

  assign busy = (state != IDLE) || !q_empty;

endmodule
